// File: rtl/dand_soc_pkg.sv
// dand_soc_pkg -- shared definitions for the DAND SoC slice.
//   CLKS_PER_BIT_DEFAULT : default UART bit period in io_axiClk cycles
//   BANNER_BYTES / BANNER_LEN : start-up banner "DAND\r\n"
//   tx_state_t / rx_state_t  : UART transmitter / receiver states
//   banner_byte()            : range-safe lookup into the banner table
package dand_soc_pkg;

   localparam int CLKS_PER_BIT_DEFAULT = 16;

   localparam int BANNER_LEN   = 6;
   localparam int BANNER_IDX_W = $clog2(BANNER_LEN + 1);
   localparam logic [7:0] BANNER_BYTES [BANNER_LEN] =
      '{8'h44, 8'h41, 8'h4E, 8'h44, 8'h0D, 8'h0A};

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_t;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

   // Index BANNER_LEN (banner finished) returns 0 instead of reading off the end.
   function automatic logic [7:0] banner_byte(input logic [BANNER_IDX_W-1:0] idx);
      banner_byte = 8'h00;
      for (int i = 0; i < BANNER_LEN; i++) begin
         if (idx == BANNER_IDX_W'(i)) begin
            banner_byte = BANNER_BYTES[i];
         end
      end
   endfunction

endpackage

// File: rtl/dand_core_cpu.sv
// dand_core_cpu -- byte sequencer feeding the UART transmitter.
//   clk, rst_n      : clock and synchronized active-low reset
//   tx_idle         : transmitter sits in IDLE
//   tx_last_stop    : transmitter is in the final cycle of a stop bit
//   hold_valid/data : received byte waiting to be echoed
//   hold_pop        : consume the held byte this cycle
//   tx_data         : byte to load into the transmitter
//   writeback_arbitration_isFiring : one-cycle strobe per byte handed to TX;
//                     doubles as the transmitter's launch command
module dand_core_cpu
   import dand_soc_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tx_idle,
   input  logic       tx_last_stop,
   input  logic       hold_valid,
   input  logic [7:0] hold_data,
   output logic       hold_pop,
   output logic [7:0] tx_data,
   output logic       writeback_arbitration_isFiring
);

   logic [BANNER_IDX_W-1:0] banner_idx_reg;
   logic                    banner_done;
   logic                    fire_banner;
   logic                    fire_echo;

   assign banner_done = (banner_idx_reg == BANNER_IDX_W'(BANNER_LEN));

   // Banner bytes may chain straight off the last stop cycle so frames are
   // back-to-back; echoed bytes wait for a genuinely idle transmitter.
   // rst_n gating keeps the strobe low while the registers are held in reset.
   assign fire_banner = rst_n && !banner_done && (tx_idle || tx_last_stop);
   assign fire_echo   = rst_n && banner_done && hold_valid && tx_idle;

   assign writeback_arbitration_isFiring = fire_banner || fire_echo;
   assign hold_pop = fire_echo;
   assign tx_data  = fire_banner ? banner_byte(banner_idx_reg) : hold_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         banner_idx_reg <= '0;
      end else if (fire_banner) begin
         banner_idx_reg <= banner_idx_reg + BANNER_IDX_W'(1);
      end
   end

endmodule

// File: rtl/dand_soc_simple.sv
// dand_soc_simple -- prints "DAND\r\n" on the UART after reset, optionally
// echoing received bytes.
//   io_axiClk      : single clock
//   io_asyncResetn : asynchronous active-low reset (release synchronized, 2 flops)
//   io_uart_txd    : UART TX, 8N1, idle high
//   io_uart_rxd    : UART RX, 8N1, idle high, asynchronous
// Parameter CLKS_PER_BIT: io_axiClk cycles per UART bit (4..65535).
// Macro DANDSOC_ECHO_EN: when defined, builds the receiver and the 1-entry
// holding register so valid received bytes are echoed after the banner;
// otherwise io_uart_rxd is ignored.
module dand_soc_simple
   import dand_soc_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
   input  logic io_axiClk,
   input  logic io_asyncResetn,
   output logic io_uart_txd,
   input  logic io_uart_rxd
);

   localparam int CNT_W = 16;
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] BIT_HALF = CNT_W'(CLKS_PER_BIT / 2);

   // ---------------- reset synchronizer ----------------
   logic [1:0] rst_sync_reg;
   logic       rst_sync_n;

   always_ff @(posedge io_axiClk or negedge io_asyncResetn) begin
      if (!io_asyncResetn) begin
         rst_sync_reg <= 2'b00;
      end else begin
         rst_sync_reg <= {rst_sync_reg[0], 1'b1};
      end
   end
   assign rst_sync_n = rst_sync_reg[1];

   // ---------------- sequencer ----------------
   logic       tx_idle;
   logic       tx_last_stop;
   logic       tx_launch;
   logic [7:0] tx_data;
   logic       hold_valid;
   logic [7:0] hold_data;
   logic       hold_pop;

   dand_core_cpu core_cpu (
      .clk                            (io_axiClk),
      .rst_n                          (rst_sync_n),
      .tx_idle                        (tx_idle),
      .tx_last_stop                   (tx_last_stop),
      .hold_valid                     (hold_valid),
      .hold_data                      (hold_data),
      .hold_pop                       (hold_pop),
      .tx_data                        (tx_data),
      .writeback_arbitration_isFiring (tx_launch)
   );

   // ---------------- UART transmitter ----------------
   tx_state_t        tx_state_reg, tx_state_next;
   logic [CNT_W-1:0] tx_baud_reg,  tx_baud_next;
   logic [2:0]       tx_bit_reg,   tx_bit_next;
   logic [7:0]       tx_shift_reg, tx_shift_next;
   logic             txd_reg,      txd_next;
   logic             tx_bit_end;

   assign tx_bit_end   = (tx_baud_reg == BIT_LAST);
   assign tx_idle      = (tx_state_reg == TX_IDLE);
   assign tx_last_stop = (tx_state_reg == TX_STOP) && tx_bit_end;

   always_comb begin
      tx_state_next = tx_state_reg;
      tx_baud_next  = tx_baud_reg;
      tx_bit_next   = tx_bit_reg;
      tx_shift_next = tx_shift_reg;
      case (tx_state_reg)
         TX_IDLE: begin
            if (tx_launch) begin
               tx_state_next = TX_START;
               tx_baud_next  = '0;
               tx_shift_next = tx_data;
            end
         end
         TX_START: begin
            if (tx_bit_end) begin
               tx_state_next = TX_DATA;
               tx_baud_next  = '0;
               tx_bit_next   = 3'd0;
            end else begin
               tx_baud_next = tx_baud_reg + 1'b1;
            end
         end
         TX_DATA: begin
            if (tx_bit_end) begin
               tx_baud_next  = '0;
               tx_shift_next = {1'b0, tx_shift_reg[7:1]};
               if (tx_bit_reg == 3'd7) begin
                  tx_state_next = TX_STOP;
               end else begin
                  tx_bit_next = tx_bit_reg + 1'b1;
               end
            end else begin
               tx_baud_next = tx_baud_reg + 1'b1;
            end
         end
         TX_STOP: begin
            if (tx_bit_end) begin
               tx_baud_next = '0;
               // Next banner byte starts with no idle gap.
               if (tx_launch) begin
                  tx_state_next = TX_START;
                  tx_shift_next = tx_data;
               end else begin
                  tx_state_next = TX_IDLE;
               end
            end else begin
               tx_baud_next = tx_baud_reg + 1'b1;
            end
         end
         default: tx_state_next = TX_IDLE;
      endcase

      // Registered line driver so txd is glitch-free.
      case (tx_state_next)
         TX_START: txd_next = 1'b0;
         TX_DATA:  txd_next = tx_shift_next[0];
         default:  txd_next = 1'b1;
      endcase
   end

   always_ff @(posedge io_axiClk or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         tx_state_reg <= TX_IDLE;
         tx_baud_reg  <= '0;
         tx_bit_reg   <= 3'd0;
         tx_shift_reg <= 8'h00;
         txd_reg      <= 1'b1;
      end else begin
         tx_state_reg <= tx_state_next;
         tx_baud_reg  <= tx_baud_next;
         tx_bit_reg   <= tx_bit_next;
         tx_shift_reg <= tx_shift_next;
         txd_reg      <= txd_next;
      end
   end
   assign io_uart_txd = txd_reg;

`ifdef DANDSOC_ECHO_EN
   // ---------------- UART receiver ----------------
   rx_state_t        rx_state_reg, rx_state_next;
   logic [CNT_W-1:0] rx_baud_reg,  rx_baud_next;
   logic [2:0]       rx_bit_reg,   rx_bit_next;
   logic [7:0]       rx_shift_reg, rx_shift_next;
   logic [2:0]       rxd_pipe_reg;     // [0] meta, [1] synced, [2] previous synced
   logic             rxd_sync;
   logic             rxd_prev;
   logic             rx_bit_end;
   logic             rx_byte_valid;
   logic             hold_valid_reg;
   logic [7:0]       hold_data_reg;

   always_ff @(posedge io_axiClk or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         rxd_pipe_reg <= 3'b111;
      end else begin
         rxd_pipe_reg <= {rxd_pipe_reg[1:0], io_uart_rxd};
      end
   end
   assign rxd_sync   = rxd_pipe_reg[1];
   assign rxd_prev   = rxd_pipe_reg[2];
   assign rx_bit_end = (rx_baud_reg == BIT_LAST);

   always_comb begin
      rx_state_next = rx_state_reg;
      rx_baud_next  = rx_baud_reg;
      rx_bit_next   = rx_bit_reg;
      rx_shift_next = rx_shift_reg;
      rx_byte_valid = 1'b0;
      case (rx_state_reg)
         RX_IDLE: begin
            if (rxd_prev && !rxd_sync) begin
               rx_state_next = RX_START;
               rx_baud_next  = '0;
            end
         end
         RX_START: begin
            // Mid-start re-check rejects glitches; afterwards every sample
            // lands a full bit period later, i.e. mid-bit.
            if (rx_baud_reg == BIT_HALF) begin
               rx_baud_next  = '0;
               rx_bit_next   = 3'd0;
               rx_state_next = rxd_sync ? RX_IDLE : RX_DATA;
            end else begin
               rx_baud_next = rx_baud_reg + 1'b1;
            end
         end
         RX_DATA: begin
            if (rx_bit_end) begin
               rx_baud_next  = '0;
               rx_shift_next = {rxd_sync, rx_shift_reg[7:1]};
               if (rx_bit_reg == 3'd7) begin
                  rx_state_next = RX_STOP;
               end else begin
                  rx_bit_next = rx_bit_reg + 1'b1;
               end
            end else begin
               rx_baud_next = rx_baud_reg + 1'b1;
            end
         end
         RX_STOP: begin
            if (rx_bit_end) begin
               rx_baud_next  = '0;
               rx_state_next = RX_IDLE;
               rx_byte_valid = rxd_sync;    // low stop bit: framing error, drop
            end else begin
               rx_baud_next = rx_baud_reg + 1'b1;
            end
         end
         default: rx_state_next = RX_IDLE;
      endcase
   end

   always_ff @(posedge io_axiClk or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         rx_state_reg <= RX_IDLE;
         rx_baud_reg  <= '0;
         rx_bit_reg   <= 3'd0;
         rx_shift_reg <= 8'h00;
      end else begin
         rx_state_reg <= rx_state_next;
         rx_baud_reg  <= rx_baud_next;
         rx_bit_reg   <= rx_bit_next;
         rx_shift_reg <= rx_shift_next;
      end
   end

   // Holding register: a new byte only lands when empty; a full register
   // keeps its older byte.
   always_ff @(posedge io_axiClk or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         hold_valid_reg <= 1'b0;
         hold_data_reg  <= 8'h00;
      end else if (rx_byte_valid && !hold_valid_reg) begin
         hold_valid_reg <= 1'b1;
         hold_data_reg  <= rx_shift_reg;
      end else if (hold_pop) begin
         hold_valid_reg <= 1'b0;
      end
   end

   assign hold_valid = hold_valid_reg;
   assign hold_data  = hold_data_reg;
`else
   logic unused_rx;
   assign hold_valid = 1'b0;
   assign hold_data  = 8'h00;
   assign unused_rx  = io_uart_rxd ^ hold_pop;
`endif

endmodule

// File: tb/tb_dand_soc_simple.sv
module tb_dand_soc_simple;

   localparam int CPB = 16;
`ifdef DANDSOC_ECHO_EN
   localparam bit ECHO_EN = 1'b1;
`else
   localparam bit ECHO_EN = 1'b0;
`endif

   typedef struct {
      logic [7:0] data;
      bit         stop_ok;
      bit         glitch;
      bit         exp_echo;
   } vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic rxd   = 1'b1;
   logic txd;
   logic fire;

   always #5 clk = ~clk;

   dand_soc_simple #(.CLKS_PER_BIT(CPB)) dut (
      .io_axiClk      (clk),
      .io_asyncResetn (rst_n),
      .io_uart_txd    (txd),
      .io_uart_rxd    (rxd)
   );

   assign fire = dut.core_cpu.writeback_arbitration_isFiring;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0] exp_banner [6] = '{8'h44, 8'h41, 8'h4E, 8'h44, 8'h0D, 8'h0A};

   // ---------------- cycle counter and txd frame monitor ----------------
   int         pcyc = 0;
   int         fire_cnt = 0;
   logic [7:0] mon_q [$];
   int         mon_start_q [$];
   bit         mon_active = 1'b0;
   int         mon_t0 = 0;
   int         mon_off = 0;
   logic [7:0] mon_byte = 8'h00;

   always @(posedge clk) pcyc++;

   always @(negedge clk) begin
      if (fire === 1'b1) fire_cnt++;
      if (!rst_n) begin
         mon_active = 1'b0;
      end else if (!mon_active) begin
         if (txd === 1'b0) begin
            mon_active = 1'b1;
            mon_t0     = pcyc;
            mon_byte   = 8'h00;
         end
      end else begin
         mon_off = pcyc - mon_t0;
         for (int k = 0; k < 8; k++) begin
            if (mon_off == CPB/2 + CPB*(k+1)) mon_byte[k] = txd;
         end
         if (mon_off == CPB/2 + 9*CPB) begin
            n_vec++;
            if (txd !== 1'b1) begin
               n_err++;
               $display("FAIL tx_stop_bit: got %b, expected 1 (frame at cycle %0d)", txd, mon_t0);
            end
            mon_q.push_back(mon_byte);
            mon_start_q.push_back(mon_t0);
            mon_active = 1'b0;
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_bytes(input int n, input int budget);
      int b;
      b = 0;
      while (mon_q.size() < n && b < budget) begin
         @(negedge clk);
         b++;
      end
   endtask

   task automatic clear_mon();
      mon_q.delete();
      mon_start_q.delete();
      fire_cnt = 0;
   endtask

   task automatic send_rx(input logic [7:0] data, input bit stop_ok);
      rxd = 1'b0;
      wait_cycles(CPB);
      for (int i = 0; i < 8; i++) begin
         rxd = data[i];
         wait_cycles(CPB);
      end
      rxd = stop_ok;
      wait_cycles(CPB);
      rxd = 1'b1;
   endtask

   // Banner followed by n_extra echoed bytes; checks content, frame timing
   // relative to the reset release cycle, and the retire count.
   task automatic check_banner(input string tag, input int rel_cyc, input int n_extra);
      wait_bytes(6 + n_extra, 20*10*CPB);
      wait_cycles(12*CPB);
      $display("%s: %0d byte(s) seen on txd, %0d retire pulse(s)", tag, mon_q.size(), fire_cnt);
      check({tag, "_count"}, mon_q.size(), 6 + n_extra);
      for (int i = 0; i < 6; i++) begin
         if (i < mon_q.size()) check($sformatf("%s_byte%0d", tag, i), mon_q[i], exp_banner[i]);
      end
      if (mon_start_q.size() > 0) check({tag, "_first_start"}, mon_start_q[0] - rel_cyc, 3);
      for (int i = 1; i < 6; i++) begin
         if (i < mon_start_q.size())
            check($sformatf("%s_gap%0d", tag, i), mon_start_q[i] - mon_start_q[i-1], 10*CPB);
      end
      check({tag, "_retires"}, fire_cnt, 6 + n_extra);
   endtask

   task automatic apply_vec(input int idx, input vec_t v);
      int f0;
      f0 = fire_cnt;
      mon_q.delete();
      mon_start_q.delete();
      if (v.glitch) begin
         rxd = 1'b0;
         wait_cycles(CPB/4);
         rxd = 1'b1;
      end else begin
         send_rx(v.data, v.stop_ok);
      end
      wait_cycles(12*CPB);
      $display("vec %0d: rx 0x%02h stop=%0d glitch=%0d -> %0d byte(s) on txd",
               idx, v.data, v.stop_ok, v.glitch, mon_q.size());
      check($sformatf("vec%0d_echo_count", idx), mon_q.size(), v.exp_echo ? 1 : 0);
      if (v.exp_echo && mon_q.size() > 0)
         check($sformatf("vec%0d_echo_byte", idx), mon_q[0], v.data);
      check($sformatf("vec%0d_retires", idx), fire_cnt - f0, v.exp_echo ? 1 : 0);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   // ---------------- main sequence ----------------
   initial begin
      vec_t vecs [3];
      vec_t rv;
      int   rel;

      vecs[0] = '{data: 8'h5A, stop_ok: 1'b1, glitch: 1'b0, exp_echo: ECHO_EN};
      vecs[1] = '{data: 8'h31, stop_ok: 1'b0, glitch: 1'b0, exp_echo: 1'b0};
      vecs[2] = '{data: 8'h00, stop_ok: 1'b1, glitch: 1'b1, exp_echo: 1'b0};

      // Power-on reset: 50 time units low.
      #20;
      check("reset_txd", txd, 1);
      check("reset_fire", fire, 0);
      #30;
      rst_n = 1'b1;
      rel = pcyc;
      check_banner("banner", rel, 0);

      // Reset reasserted during banner byte 2.
      clear_mon();
      @(negedge clk); #1;
      rst_n = 1'b0;
      #1000;
      rst_n = 1'b1;
      rel = pcyc;
      wait_bytes(2, 6*10*CPB);
      wait_cycles(40);
      #1;
      rst_n = 1'b0;
      #1;
      check("midreset_txd", txd, 1);
      check("midreset_fire", fire, 0);
      #5000;
      clear_mon();
      rst_n = 1'b1;
      rel = pcyc;
      check_banner("rebanner", rel, 0);

      // Table-driven RX vectors after the banner.
      for (int i = 0; i < 3; i++) apply_vec(i, vecs[i]);

      // Randomized RX bytes: echoed only when the frame is valid and echo is built.
      for (int i = 0; i < 8; i++) begin
         rv.data     = 8'($urandom);
         rv.glitch   = ($urandom_range(0, 5) == 0);
         rv.stop_ok  = ($urandom_range(0, 3) != 0);
         rv.exp_echo = ECHO_EN && rv.stop_ok && !rv.glitch;
         apply_vec(3 + i, rv);
      end

      // Three bytes during the banner: only the first is held and echoed.
      @(negedge clk); #1;
      rst_n = 1'b0;
      #100;
      clear_mon();
      rst_n = 1'b1;
      rel = pcyc;
      wait_cycles(20);
      send_rx(8'h61, 1'b1);
      send_rx(8'h62, 1'b1);
      send_rx(8'h63, 1'b1);
      check_banner("overflow", rel, ECHO_EN ? 1 : 0);
      if (ECHO_EN && mon_q.size() > 6) check("overflow_echo_byte", mon_q[6], 8'h61);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
